// File: rtl/countdown_timer.sv
// Two-digit BCD seconds countdown (59..00) with load/start/pause control, tick prescaler and
// registered seven-segment outputs. Define COUNTDOWN_BLINK_EN to blink the display while expired.
module countdown_timer #(
    parameter int CLK_HZ  = 1_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_tens_i,
    input  logic [3:0] load_ones_i,
    input  logic       start_i,
    input  logic       pause_i,
    output logic [6:0] digital_10_o,
    output logic [6:0] digital_1_o,
    output logic       running_o,
    output logic       expired_o,
    output logic       done_o
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
`ifdef COUNTDOWN_BLINK_EN
    localparam logic [PW-1:0] PHALF = PW'(PRESCALE / 2);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     tens_q, tens_d;
    logic [3:0]     ones_q, ones_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           done_q, done_d;
    logic           running_q, expired_q;
    logic [6:0]     seg10_q, seg1_q;
    logic           tick_s;
    logic           nonzero_s;
    logic           blank_s;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign tick_s    = (state_q == ST_RUN) && (presc_q == PMAX);
    assign nonzero_s = (tens_q != 4'd0) || (ones_q != 4'd0);

    // Display blanking during the dark half of the expiry blink
    always_comb begin
`ifdef COUNTDOWN_BLINK_EN
        blank_s = (state_q == ST_EXPIRED) && (presc_q >= PHALF);
`else
        blank_s = 1'b0;
`endif
    end

    // Next-state, digit and prescaler logic; load beats pause beats start
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (load_i) begin
            state_d = ST_IDLE;
            tens_d  = (load_tens_i > 4'd5) ? 4'd5 : load_tens_i;
            ones_d  = (load_ones_i > 4'd9) ? 4'd9 : load_ones_i;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !pause_i && nonzero_s) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A pause freezes the prescaler on the very edge it is seen
                    if (pause_i) begin
                        state_d = ST_PAUSED;
                    end else if (tick_s) begin
                        presc_d = '0;
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                            if ((tens_q == 4'd0) && (ones_q == 4'd1)) begin
                                state_d = ST_EXPIRED;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (start_i && !pause_i) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_EXPIRED: begin
`ifdef COUNTDOWN_BLINK_EN
                    presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
`else
                    presc_d = '0;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State, digit, prescaler and registered output updates
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            seg10_q   <= 7'h3F;
            seg1_q    <= 7'h3F;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
            seg10_q   <= blank_s ? 7'h00 : seg7(tens_q);
            seg1_q    <= blank_s ? 7'h00 : seg7(ones_q);
        end
    end

    assign digital_10_o = seg10_q;
    assign digital_1_o  = seg1_q;
    assign running_o    = running_q;
    assign expired_o    = expired_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds-level reference model queues expected outputs
// per cycle; a monitor compares them one cycle later. Directed scenarios then random traffic.
module tb_countdown_timer;

    localparam int P = 4;
`ifdef COUNTDOWN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] digital_10, digital_1;
    logic       running, expired, done;

    countdown_timer #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk_i(clk), .rst_i(rst), .load_i(load), .load_tens_i(load_tens), .load_ones_i(load_ones),
        .start_i(start), .pause_i(pause), .digital_10_o(digital_10), .digital_1_o(digital_1),
        .running_o(running), .expired_o(expired), .done_o(done)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic [16:0] sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_no   = 0;
    string       phase    = "reset";

    // Reference model: whole-second value, mode and sub-second count
    int m_val  = 0;
    int m_mode = M_IDLE;
    int m_sub  = 0;

    task automatic cyc(input bit r, input bit ld, input int lt, input int lo, input bit st, input bit pa);
        int  disp;
        bit  blank;
        bit  dn;
        logic [6:0] e10, e1;
        rst = r; load = ld; load_tens = 4'(lt); load_ones = 4'(lo); start = st; pause = pa;
        disp  = m_val;
        blank = BLINK && (m_mode == M_EXP) && (m_sub >= P / 2);
        dn    = 1'b0;
        if (r) begin
            m_val = 0; m_mode = M_IDLE; m_sub = 0;
        end else if (ld) begin
            m_val  = ((lt > 5) ? 5 : lt) * 10 + ((lo > 9) ? 9 : lo);
            m_mode = M_IDLE; m_sub = 0;
        end else begin
            case (m_mode)
                M_IDLE:   if (st && !pa && m_val != 0) begin m_mode = M_RUN; m_sub = 0; end
                M_RUN: begin
                    if (pa) m_mode = M_PAUSED;
                    else if (m_sub == P - 1) begin
                        m_sub = 0;
                        m_val = m_val - 1;
                        if (m_val == 0) begin m_mode = M_EXP; dn = 1'b1; end
                    end else m_sub = m_sub + 1;
                end
                M_PAUSED: if (st && !pa) m_mode = M_RUN;
                default:  m_sub = BLINK ? (m_sub + 1) % P : 0;
            endcase
        end
        if (r) begin
            e10 = 7'h3F; e1 = 7'h3F;
        end else if (blank) begin
            e10 = 7'h00; e1 = 7'h00;
        end else begin
            e10 = seg_tab[disp / 10]; e1 = seg_tab[disp % 10];
        end
        sb_q.push_back({e10, e1, (m_mode == M_RUN), (m_mode == M_EXP), dn});
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs just after each edge with the oldest expectation
    always begin
        logic [16:0] e;
        logic [16:0] a;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {digital_10, digital_1, running, expired, done};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got seg10=%h seg1=%h run=%b exp=%b done=%b, expected seg10=%h seg1=%h run=%b exp=%b done=%b",
                         phase, cyc_no, a[16:10], a[9:3], a[2], a[1], a[0], e[16:10], e[9:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        phase = "reset";
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(2);

        phase = "count_12";
        cyc(1'b0, 1'b1, 1, 2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(20);

        phase = "expire_02";
        cyc(1'b0, 1'b1, 0, 2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(12);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(6);

        phase = "pause_resume_30";
        cyc(1'b0, 1'b1, 3, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle(20);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(6);

        phase = "clamp_7C";
        cyc(1'b0, 1'b1, 7, 12, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        idle(3);
        cyc(1'b0, 1'b1, 15, 15, 1'b0, 1'b0);
        idle(2);

        phase = "zero_start";
        cyc(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(3);

        phase = "load_with_start";
        cyc(1'b0, 1'b1, 2, 0, 1'b1, 1'b0);
        idle(6);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(6);

        phase = "rst_mid_run";
        cyc(1'b0, 1'b1, 4, 5, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(2);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(4);

        phase = "expired_display";
        cyc(1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(16);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 89) == 0),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
        end

        idle(1);
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
